// File: rtl/counter_seq.sv
// Command sequencer for an up/down counter: accepts LOAD/UP/DOWN/HOLD commands,
// drives the counter cycle-accurately, and reports wraps and final-count mismatches.
module counter_seq #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_val,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] count,
    output logic             load_en,
    output logic [WIDTH-1:0] load,
    output logic             down,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] wrap_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_HOLD = 2'b11
    } op_t;

    state_t           r_state;
    op_t              r_op;
    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] r_exp;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_wrap;

    logic [WIDTH-1:0] w_len_mod;
    logic             w_wrap;
    op_t              w_op;

    // Step length reduced mod 2^WIDTH for the expected-final-value arithmetic.
    assign w_len_mod = WIDTH'(cmd_len);
    assign w_op      = op_t'(cmd_op);
    assign w_wrap    = ((r_op == OP_UP)   && (count == '1)) ||
                       ((r_op == OP_DOWN) && (count == '0));
    assign wrap_cnt  = r_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wrap  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= w_op;
                        r_val  <= cmd_val;
                        r_rem  <= cmd_len;
                        r_wrap <= '0;
                        case (w_op)
                            OP_LOAD: r_exp <= cmd_val;
                            OP_UP:   r_exp <= count + w_len_mod;
                            OP_DOWN: r_exp <= count - w_len_mod;
                            default: r_exp <= count;
                        endcase
                        if (w_op == OP_LOAD)
                            r_state <= ST_LOAD;
                        else if (cmd_len == '0)
                            r_state <= ST_DONE;
                        else
                            r_state <= ST_RUN;
                    end
                end
                ST_LOAD: r_state <= ST_DONE;
                ST_RUN: begin
                    if (w_wrap && (r_wrap != '1))
                        r_wrap <= r_wrap + LEN_W'(1);
                    if (r_rem == LEN_W'(1))
                        r_state <= ST_DONE;
                    else
                        r_rem <= r_rem - LEN_W'(1);
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from state; reset forces them low in the same cycle.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        load_en   = 1'b0;
        load      = '0;
        down      = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    load_en   = 1'b1;
                    load      = count;
                end
                ST_LOAD: begin
                    busy    = 1'b1;
                    load_en = 1'b1;
                    load    = r_val;
                end
                ST_RUN: begin
                    busy = 1'b1;
                    if (r_op == OP_DOWN) begin
                        down = 1'b1;
                    end else if (r_op == OP_HOLD) begin
                        load_en = 1'b1;
                        load    = count;
                    end
                end
                ST_DONE: begin
                    busy    = 1'b1;
                    done    = 1'b1;
                    err     = (count != r_exp);
                    load_en = 1'b1;
                    load    = count;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq.sv
// Randomized self-checking bench for counter_seq with a transaction-level model
// of command latency, final count and wrap totals, plus directed literal checks.
module tb_counter_seq;

    localparam int W = 4;
    localparam int L = 8;
    localparam int M = 1 << W;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [W-1:0]   cmd_val;
    logic [L-1:0]   cmd_len;
    logic [W-1:0]   cnt_in;
    logic           load_en;
    logic [W-1:0]   load;
    logic           down;
    logic           busy;
    logic           done;
    logic [L-1:0]   wrap_cnt;
    logic           err;

    logic [W-1:0]   ctr = '0;
    logic           inject = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    counter_seq #(.WIDTH(W), .LEN_W(L)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_val(cmd_val), .cmd_len(cmd_len), .count(cnt_in),
        .load_en(load_en), .load(load), .down(down), .busy(busy), .done(done),
        .wrap_cnt(wrap_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Free-running counter driven by the sequencer; inject forces the observed value.
    always @(posedge clk)
        ctr <= load_en ? load : (down ? ctr - 1'b1 : ctr + 1'b1);
    assign cnt_in = inject ? 4'h3 : ctr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: per-command latency, final value and wrap count by arithmetic.
    bit m_armed = 0;
    bit m_busy = 0;
    int m_left, m_op, m_val, m_start, m_len, m_final, m_wexp;
    int m_wrap = 0;

    always @(negedge clk) begin
        bit exp_done;
        if (rst) m_armed = 1;
        if (m_armed) begin
            if (m_busy) m_left--;
            exp_done = m_busy && (m_left == 0);
            if (rst) begin
                chk("rst_ready", cmd_ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err, 0);
                chk("rst_load_en", load_en, 0);
                chk("rst_load", load, 0);
                chk("rst_down", down, 0);
                m_busy = 0;
                m_wrap = 0;
            end else begin
                chk("ready", cmd_ready, !m_busy);
                chk("busy", busy, m_busy);
                chk("done", done, exp_done);
                if (!m_busy || exp_done || (m_op == 3 && m_busy) ) begin
                    chk("hold_load_en", load_en, 1);
                    chk("hold_down", down, 0);
                    chk("hold_load", load, cnt_in);
                end else if (m_op == 0) begin
                    chk("ld_load_en", load_en, 1);
                    chk("ld_down", down, 0);
                    chk("ld_load", load, m_val);
                end else begin
                    chk("run_load_en", load_en, 0);
                    chk("run_down", down, m_op == 2);
                end
                if (!m_busy) begin
                    chk("idle_err", err, 0);
                    chk("idle_wrap", wrap_cnt, m_wrap);
                end
                if (exp_done) begin
                    chk("done_err", err, cnt_in != m_final);
                    chk("done_wrap", wrap_cnt, m_wexp);
                    chk("done_count", ctr, m_final);
                    m_busy = 0;
                    m_wrap = m_wexp;
                end else if (!m_busy && cmd_valid) begin
                    m_busy  = 1;
                    m_op    = cmd_op;
                    m_val   = cmd_val;
                    m_len   = cmd_len;
                    m_start = cnt_in;
                    m_wrap  = 0;
                    case (m_op)
                        0: begin m_final = m_val; m_wexp = 0; m_left = 2; end
                        1: begin
                            m_final = (m_start + m_len) % M;
                            m_wexp  = (m_start + m_len) / M;
                        end
                        2: begin
                            m_final = (m_start + M * 256 - m_len) % M;
                            m_wexp  = (m_len + M - 1 - m_start) / M;
                        end
                        default: begin m_final = m_start; m_wexp = 0; end
                    endcase
                    if (m_wexp > (1 << L) - 1) m_wexp = (1 << L) - 1;
                    if (m_op != 0) m_left = (m_len == 0) ? 1 : m_len + 1;
                end
            end
        end
    end

    // Issue one command and wait for its done pulse; optionally force count on cycle inj_at.
    task automatic do_cmd(input int op, input int val, input int len, input int inj_at,
                          output int lat, output int fcnt, output int ferr, output int fwrap);
        int k;
        bit ok;
        lat = -1; fcnt = -1; ferr = -1; fwrap = -1;
        cmd_valid = 1; cmd_op = 2'(op); cmd_val = W'(val); cmd_len = L'(len);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
            @(posedge clk); #2;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 0;
            return;
        end
        @(posedge clk); #2;
        cmd_valid = 0;
        ok = 0;
        for (k = 1; k < 400; k++) begin
            if (k == inj_at) inject = 1;
            @(negedge clk);
            if (done) begin ok = 1; break; end
            @(posedge clk); #2;
        end
        if (!ok) chk("done_timeout", 0, 1);
        else begin lat = k; fcnt = ctr; ferr = err; fwrap = wrap_cnt; end
        @(posedge clk); #2;
        inject = 0;
    endtask

    initial begin
        int lat, fc, fe, fw;
        rst = 1; cmd_valid = 0; cmd_op = '0; cmd_val = '0; cmd_len = '0;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_wrap", wrap_cnt, 0);
        @(posedge clk); #2;

        do_cmd(0, 9, 0, 0, lat, fc, fe, fw);
        chk("load9_lat", lat, 2); chk("load9_cnt", fc, 9);
        chk("load9_err", fe, 0); chk("load9_wrap", fw, 0);

        do_cmd(0, 13, 0, 0, lat, fc, fe, fw);
        do_cmd(1, 0, 5, 0, lat, fc, fe, fw);
        chk("up5_lat", lat, 6); chk("up5_cnt", fc, 2);
        chk("up5_wrap", fw, 1); chk("up5_err", fe, 0);

        do_cmd(0, 1, 0, 0, lat, fc, fe, fw);
        do_cmd(2, 0, 3, 0, lat, fc, fe, fw);
        chk("dn3_lat", lat, 4); chk("dn3_cnt", fc, 14); chk("dn3_wrap", fw, 1);
        do_cmd(3, 0, 4, 0, lat, fc, fe, fw);
        chk("hold4_lat", lat, 5); chk("hold4_cnt", fc, 14); chk("hold4_err", fe, 0);

        do_cmd(1, 0, 0, 0, lat, fc, fe, fw);
        chk("up0_lat", lat, 1); chk("up0_cnt", fc, 14); chk("up0_err", fe, 0);
        chk("up0_wrap", fw, 0);

        do_cmd(0, 2, 0, 0, lat, fc, fe, fw);
        do_cmd(1, 0, 5, 6, lat, fc, fe, fw);
        chk("inject_lat", lat, 6); chk("inject_err", fe, 1);

        // cmd_valid held high with changing fields; only IDLE acceptances may occur
        cmd_valid = 1;
        for (int i = 0; i < 30; i++) begin
            cmd_op  = 2'($urandom_range(0, 3));
            cmd_val = W'($urandom);
            cmd_len = L'($urandom_range(0, 5));
            @(posedge clk); #2;
        end
        cmd_valid = 0;
        repeat (10) @(posedge clk);
        #2;

        for (int i = 0; i < 40; i++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
            do_cmd($urandom_range(0, 3), $urandom, len, 0, lat, fc, fe, fw);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2;
        end

        // Reset during the third cycle after acceptance of a long UP aborts it
        do_cmd(0, 0, 0, 0, lat, fc, fe, fw);
        cmd_valid = 1; cmd_op = 2'd1; cmd_len = 8'd10;
        @(negedge clk);
        chk("abort_ready", cmd_ready, 1);
        @(posedge clk); #2;
        cmd_valid = 0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1;
        @(posedge clk); #2;
        rst = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_ready2", cmd_ready, 1);
        chk("abort_wrap", wrap_cnt, 0);
        repeat (15) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
